// File: rtl/mod_counter.sv
// mod_counter: synchronous modulo counter with up/down, wrap/saturate modes.
//
// All state changes happen on one clock edge (no ripple).
// Ports:
//   clk   - clock, all registers update on posedge
//   rstn  - asynchronous active-low reset
//   en    - count enable
//   clr   - synchronous clear (highest priority)
//   load  - synchronous parallel load of din, clamped to MODULO-1
//   din   - load value
//   mode  - 00 up-wrap, 01 down-wrap, 10 up-saturate, 11 down-saturate
//   out   - registered binary count, always in 0..MODULO-1
//   gray  - registered Gray code of out
//   tc    - combinational terminal count, high the cycle before a wrap edge
//   wrap  - registered one-cycle pulse following a wrapping edge
module mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
    $error("mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

  logic             count_up;
  logic             saturate;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;

  assign count_up = ~mode[0];
  assign saturate = mode[1];
  assign term_val = count_up ? MAX_CNT : '0;
  assign at_term  = (out == term_val);

  assign tc = en & ~clr & ~load & at_term & ~saturate;

  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    if (clr) begin
      out_nxt = '0;
    end else if (load) begin
      // clamp so an out-of-range load can never create an unreachable count
      out_nxt = (din > MAX_CNT) ? MAX_CNT : din;
    end else if (en) begin
      if (at_term) begin
        if (!saturate) begin
          out_nxt  = count_up ? '0 : MAX_CNT;
          wrap_nxt = 1'b1;
        end
      end else if (count_up) begin
        out_nxt = out + 1'b1;
      end else begin
        out_nxt = out - 1'b1;
      end
    end
  end

  // gray is derived from out_nxt so it tracks out in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= out_nxt;
      gray <= out_nxt ^ (out_nxt >> 1);
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo counter, successor to the 4-bit ripple counter in the counter library. It adds the following over the ripple counter:
- configurable width and modulus;
- up/down counting with wrap or saturate modes;
- synchronous clear and parallel load;
- a combinational terminal-count output for cascading;
- a registered wrap pulse and a Gray-coded copy of the count.

All state changes on one clock edge, so there are no ripple delays.

## Interface
- WIDTH, 4: count register width in bits.
- MODULO, 16: count range is 0..MODULO-1. Legal range is 2 <= MODULO <= 2**WIDTH; outside that range the block is illegal and elaboration must error.
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- mode  input  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 down-saturate.
- out  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of out (out ^ (out>>1)).
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle wrap pulse.

## Operation
- Reset (rstn=0, asynchronous, no clock needed): out=0, gray=0, wrap=0. tc then follows its equation with out=0.
- Per-edge priority is clr > load > en.
  - clr=1: out<=0; wrap<=0.
  - load=1 (clr=0): out<=min(din, MODULO-1); wrap<=0. Out-of-range load values clamp and never produce an illegal count.
  - en=1 (clr=0, load=0): step according to mode.
  - Otherwise: hold; wrap<=0.
- Terminal value T: MODULO-1 for up modes (mode[0]=0), 0 for down modes (mode[0]=1).
- Step rules:
  - Up, out<T: out<=out+1.
  - Down, out>T: out<=out-1.
  - At T in wrap mode (mode[1]=0): up goes to 0, down goes to MODULO-1; wrap<=1 for exactly that edge.
  - At T in saturate mode (mode[1]=1): out holds at T; wrap<=0.
  - wrap is 0 after every edge that is not a wrap event.
- tc = en & ~clr & ~load & (out==T) & ~mode[1]. It is asserted in the cycle before a wrap edge, so tc of stage N can drive en of stage N+1 when cascading.
- Mode changes take effect on the same edge. If mode flips direction while out==T of the old direction, no wrap occurs.
- Arithmetic is modulo MODULO, not 2**WIDTH. For non-power-of-two MODULO, values >= MODULO are unreachable by every path: reset, clr, load clamp and step.
- gray is registered from the next-state value, so gray always equals out ^ (out>>1) in the same cycle.

## Timing
- Latency: clr, load and en act on the first posedge where they are sampled high; out and gray update together.
- wrap is high during the cycle after the wrapping edge, concurrent with the new out (0 or MODULO-1).
- tc is combinational from out, en, clr, load and mode, with no register stage.
- Reset deassertion is synchronised externally. First count occurs on the first posedge with rstn=1 and en=1.
- Reset asserted mid-count clears all registers immediately, asynchronously. Register state is fully cleared; tc follows its equation with out=0.

## Test plan
All scenarios use WIDTH=4, MODULO=10 unless noted.
- **Reset and up-wrap:** rstn=0 for 4 clocks, then en=1, mode=00 for 25 clocks.
  - out runs 0..9,0..9,0..4.
  - wrap is high in the cycles where out=0 after 9.
  - tc is high while out=9.
  - gray matches out^(out>>1) every cycle.
- **Down-wrap and saturate:** load din=3, then mode=01, en=1.
  - Required sequence: 3,2,1,0,9,8, with wrap high at the 9.
  - Then mode=11 from out=2: sequence 2,1,0,0,0; wrap=0 and tc=0 throughout.
- **Priority and clamp:**
  - clr=1 and load=1 with din=5 on the same edge: out=0.
  - load=1 with din=15: out=9.
  - load=1 and en=1 with din=4: out=4, not 5.
- **Cascade:** two instances with MODULO=10, stage-1 en tied to stage-0 tc, both up-wrap.
  - After 123 enabled clocks from reset: stage0 out=3, stage1 out=2.
- **Async reset mid-operation:** pulse rstn low between edges while out=7.
  - out, gray and wrap go to 0 before the next posedge.
  - Counting resumes from 0.
- **Power-of-two modulus:** WIDTH=4, MODULO=16, mode=00, 20 enabled clocks.
  - out runs 0..15,0..3.
  - wrap is high once, in the cycle out=0 after 15.
